// File: rtl/wlseq_pkg.sv
// ============================================================================
// wlseq_pkg : shared constants for the word-line program sequencer
// Revision  : 1.0
// ============================================================================
`default_nettype none

`ifndef ARRAY_SIZE
`define ARRAY_SIZE 50
`endif

package wlseq_pkg;

  localparam int DEF_ARRAY_SIZE       = `ARRAY_SIZE;
  localparam int ROW_W                = $clog2(DEF_ARRAY_SIZE);
  localparam int DEF_WEIGHT_BITS      = 4;
  localparam int DEF_PRECHARGE_CYCLES = 2;
  localparam int DEF_WRITE_CYCLES     = 2;

  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_FETCH = 3'd1;
  localparam logic [STATE_W-1:0] ST_PRECH = 3'd2;
  localparam logic [STATE_W-1:0] ST_WRITE = 3'd3;
  localparam logic [STATE_W-1:0] ST_GAP   = 3'd4;
  localparam logic [STATE_W-1:0] ST_DONE  = 3'd5;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wlseq_phase_timer.sv
// ============================================================================
// wlseq_phase_timer : loadable down counter with zero flag for phase lengths
// Revision          : 1.0
// ============================================================================
`default_nettype none

module wlseq_phase_timer #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

`default_nettype wire

// File: rtl/wl_program_sequencer.sv
// ============================================================================
// wl_program_sequencer : fetch / precharge / write / gap sequencing per word line
// Optional macro WLSEQ_SINGLE_ROW_EN adds single_row / row_sel ports.
// Revision             : 1.0
// ============================================================================
`default_nettype none

module wl_program_sequencer
  import wlseq_pkg::*;
#(
  parameter int ARRAY_SIZE       = DEF_ARRAY_SIZE,
  parameter int WEIGHT_BITS      = DEF_WEIGHT_BITS,
  parameter int PRECHARGE_CYCLES = DEF_PRECHARGE_CYCLES,
  parameter int WRITE_CYCLES     = DEF_WRITE_CYCLES
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              abort,
  output logic                              busy,
  output logic                              done,
  input  logic                              row_valid,
  output logic                              row_ready,
  input  logic [ARRAY_SIZE*WEIGHT_BITS-1:0] row_data,
  output logic                              address_enable,
  output logic [$clog2(ARRAY_SIZE)-1:0]     WL_num,
  output logic                              prechargeb,
  output logic [ARRAY_SIZE*WEIGHT_BITS-1:0] bl_data,
  output logic                              bl_drive_en
`ifdef WLSEQ_SINGLE_ROW_EN
  ,
  input  logic                              single_row,
  input  logic [$clog2(ARRAY_SIZE)-1:0]     row_sel
`endif
);

  localparam int WL_W   = $clog2(ARRAY_SIZE);
  localparam int DATA_W = ARRAY_SIZE * WEIGHT_BITS;
  localparam int CNT_W  = $clog2(max_int(PRECHARGE_CYCLES, WRITE_CYCLES) + 1);
  localparam logic [WL_W-1:0] LAST_ROW = WL_W'(ARRAY_SIZE - 1);

  logic [STATE_W-1:0] state, next_state;
  logic               fire, accept_start, last_row;
  logic [WL_W-1:0]    start_row;
  logic               timer_load, timer_zero;
  logic [CNT_W-1:0]   timer_value;

  logic               busy_d, done_d, ready_d, ae_d, prechb_d, drive_d;
  logic [WL_W-1:0]    wl_d;
  logic [DATA_W-1:0]  bl_d;

  assign fire = row_valid && row_ready;

`ifdef WLSEQ_SINGLE_ROW_EN
  logic single_mode;

  assign accept_start = start && !abort && (!single_row || (int'(row_sel) < ARRAY_SIZE));
  assign start_row    = single_row ? row_sel : '0;
  assign last_row     = single_mode || (WL_num == LAST_ROW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      single_mode <= 1'b0;
    end else if (state == ST_IDLE && accept_start) begin
      single_mode <= single_row;
    end
  end
`else
  assign accept_start = start && !abort;
  assign start_row    = '0;
  assign last_row     = (WL_num == LAST_ROW);
`endif

  wlseq_phase_timer #(.WIDTH(CNT_W)) u_phase_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (timer_load),
    .load_value (timer_value),
    .zero       (timer_zero)
  );

  // State and every output are registered together so outputs track the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      row_ready      <= 1'b0;
      address_enable <= 1'b0;
      prechargeb     <= 1'b1;
      WL_num         <= '0;
      bl_data        <= '0;
      bl_drive_en    <= 1'b0;
    end else begin
      state          <= next_state;
      busy           <= busy_d;
      done           <= done_d;
      row_ready      <= ready_d;
      address_enable <= ae_d;
      prechargeb     <= prechb_d;
      WL_num         <= wl_d;
      bl_data        <= bl_d;
      bl_drive_en    <= drive_d;
    end
  end

  always_comb begin
    next_state = state;
    if (state != ST_IDLE && abort) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (accept_start) next_state = ST_FETCH;
        ST_FETCH: if (fire)         next_state = ST_PRECH;
        ST_PRECH: if (timer_zero)   next_state = ST_WRITE;
        ST_WRITE: if (timer_zero)   next_state = ST_GAP;
        ST_GAP:   next_state = last_row ? ST_DONE : ST_FETCH;
        ST_DONE:  next_state = ST_IDLE;
        default:  next_state = ST_IDLE;
      endcase
    end
    timer_load  = ((state == ST_FETCH) && (next_state == ST_PRECH)) ||
                  ((state == ST_PRECH) && (next_state == ST_WRITE));
    timer_value = (state == ST_FETCH) ? CNT_W'(PRECHARGE_CYCLES - 1)
                                      : CNT_W'(WRITE_CYCLES - 1);
  end

  always_comb begin
    busy_d   = (next_state != ST_IDLE) && (next_state != ST_DONE);
    done_d   = (next_state == ST_DONE);
    ready_d  = (next_state == ST_FETCH);
    ae_d     = (next_state == ST_WRITE);
    prechb_d = (next_state != ST_PRECH);
    drive_d  = (next_state == ST_WRITE);
    wl_d     = WL_num;
    bl_d     = bl_data;
    if (state != ST_IDLE && abort) begin
      wl_d = '0;
      bl_d = '0;
    end else begin
      case (state)
        ST_IDLE:  if (accept_start) wl_d = start_row;
        ST_FETCH: if (fire)         bl_d = row_data;
        ST_GAP:   if (!last_row)    wl_d = WL_num + WL_W'(1);
        ST_DONE:  wl_d = '0;
        default:  ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wl_program_sequencer.sv
// ============================================================================
// tb_wl_program_sequencer : randomized bench with a phase-timeline reference model
// Revision                : 1.0
// ============================================================================
`default_nettype none

module tb_wl_program_sequencer;
  import wlseq_pkg::*;

  localparam int N  = DEF_ARRAY_SIZE;
  localparam int WB = 4;
  localparam int P  = 2;
  localparam int W  = 2;
  localparam int DW = N * WB;
  localparam int RW = $clog2(N);
  localparam int PH_IDLE = -1;
  localparam int PH_DONE = -2;
`ifdef WLSEQ_SINGLE_ROW_EN
  localparam bit SR = 1'b1;
`else
  localparam bit SR = 1'b0;
`endif

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, row_valid = 1'b0;
  logic [DW-1:0] row_data = '0;
  logic          single_row = 1'b0;
  logic [RW-1:0] row_sel = '0;
  logic          busy, done, row_ready, address_enable, prechargeb, bl_drive_en;
  logic [RW-1:0] WL_num;
  logic [DW-1:0] bl_data;

  always #5 clk = ~clk;

  wl_program_sequencer #(
    .ARRAY_SIZE(N), .WEIGHT_BITS(WB), .PRECHARGE_CYCLES(P), .WRITE_CYCLES(W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy), .done(done),
    .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
    .address_enable(address_enable), .WL_num(WL_num), .prechargeb(prechargeb),
    .bl_data(bl_data), .bl_drive_en(bl_drive_en)
`ifdef WLSEQ_SINGLE_ROW_EN
    , .single_row(single_row), .row_sel(row_sel)
`endif
  );

  int checks = 0, passes = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else passes++;
  endtask

  // Reference: phase position within a row (0 fetch, 1..P precharge,
  // P+1..P+W write, P+W+1 gap) plus the current row number.
  int            ph = PH_IDLE, row = 0;
  bit            msingle = 1'b0;
  logic [DW-1:0] mbl = '0;
  logic [DW-1:0] row_log [N];
  int            done_count = 0, ae_pulses = 0;
  logic          prev_ae = 1'b0;
  logic [RW-1:0] prev_wl = '0;

  function automatic logic [DW-1:0] rand_row();
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < (DW + 31) / 32; i++) r = (r << 32) | DW'($urandom);
    return r;
  endfunction

  task automatic model_reset();
    ph = PH_IDLE; row = 0; mbl = '0; msingle = 1'b0; prev_ae = 1'b0; prev_wl = '0;
  endtask

  task automatic model_advance(input logic s, input logic a, input logic v,
                               input logic [DW-1:0] d, input logic sr, input logic [RW-1:0] rs);
    if (ph == PH_IDLE) begin
      if (s && !a) begin
        if (SR && sr) begin
          if (int'(rs) < N) begin ph = 0; row = int'(rs); msingle = 1'b1; end
        end else begin
          ph = 0; row = 0; msingle = 1'b0;
        end
      end
    end else if (a) begin
      ph = PH_IDLE; row = 0; mbl = '0;
    end else if (ph == 0) begin
      if (v) begin mbl = d; row_log[row] = d; ph = 1; end
    end else if (ph >= 1 && ph <= P + W) begin
      ph++;
    end else if (ph == P + W + 1) begin
      if (row == N - 1 || msingle) ph = PH_DONE;
      else begin row++; ph = 0; end
    end else begin
      ph = PH_IDLE; row = 0;
    end
  endtask

  task automatic compare_all();
    logic e_ae;
    e_ae = (ph > P) && (ph <= P + W);
    check("busy",        256'(busy),           256'(ph >= 0));
    check("done",        256'(done),           256'(ph == PH_DONE));
    check("row_ready",   256'(row_ready),      256'(ph == 0));
    check("addr_en",     256'(address_enable), 256'(e_ae));
    check("prechargeb",  256'(prechargeb),     256'(!(ph >= 1 && ph <= P)));
    check("bl_drive_en", 256'(bl_drive_en),    256'(e_ae));
    check("wl_num",      256'(WL_num),         256'(row));
    check("bl_data",     256'(bl_data),        256'(mbl));
    check("inv_ae_pch",  256'(address_enable & ~prechargeb), 256'(0));
    if (address_enable) check("bl_vs_row_log", 256'(bl_data), 256'(row_log[WL_num]));
    if (prev_ae && address_enable) check("inv_wl_hold", 256'(WL_num), 256'(prev_wl));
    if (done) done_count++;
    if (address_enable && !prev_ae) ae_pulses++;
    prev_ae = address_enable;
    prev_wl = WL_num;
  endtask

  task automatic step();
    logic s, a, v, sr;
    logic [DW-1:0] d;
    logic [RW-1:0] rs;
    s = start; a = abort; v = row_valid; d = row_data; sr = single_row; rs = row_sel;
    @(posedge clk);
    model_advance(s, a, v, d, sr, rs);
    #1;
    compare_all();
  endtask

  task automatic run_to_idle(input int budget, input int valid_pct);
    for (int i = 0; i < budget && ph != PH_IDLE; i++) begin
      row_valid = ($urandom_range(99) < valid_pct);
      row_data  = rand_row();
      step();
    end
    check("idle_timeout_busy", 256'(busy), 256'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc, done_cyc, stall;

    repeat (2) @(posedge clk);
    #1;
    model_reset();
    compare_all();
    rst_n = 1'b1;

    // Full program with row_valid held high: latency and pulse count.
    done_count = 0; ae_pulses = 0; done_cyc = 0;
    row_valid = 1'b1; row_data = rand_row(); start = 1'b1;
    step();
    start = 1'b0; cyc = 1;
    for (int i = 0; i < 400 && ph != PH_IDLE; i++) begin
      row_data = rand_row();
      step();
      cyc++;
      if (done && done_cyc == 0) done_cyc = cyc;
    end
    check("full_done_cycle", 256'(done_cyc),   256'(N * (P + W + 2) + 1));
    check("full_ae_pulses",  256'(ae_pulses),  256'(N));
    check("full_done_once",  256'(done_count), 256'(1));
    check("full_wl_end",     256'(WL_num),     256'(0));
    check("full_busy_end",   256'(busy),       256'(0));

    // Backpressure: five stalled cycles in row 7's fetch.
    done_count = 0; stall = 0;
    row_valid = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 600 && ph != PH_IDLE; i++) begin
      if (ph == 0 && row == 7 && stall < 5) begin row_valid = 1'b0; stall++; end
      else row_valid = 1'b1;
      row_data = rand_row();
      step();
      if (ph == 0 && row == 7) begin
        check("stall_ae",   256'(address_enable), 256'(0));
        check("stall_pchb", 256'(prechargeb),     256'(1));
      end
    end
    check("bp_stall_count", 256'(stall),      256'(5));
    check("bp_done_once",   256'(done_count), 256'(1));

    // Abort in the second write cycle of row 20.
    done_count = 0;
    row_valid = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 500 && !(row == 20 && ph == P + W); i++) begin
      row_data = rand_row();
      step();
    end
    check("abort_reach_wl", 256'(WL_num),         256'(20));
    check("abort_reach_ae", 256'(address_enable), 256'(1));
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", 256'(busy),           256'(0));
    check("abort_ae",   256'(address_enable), 256'(0));
    check("abort_wl",   256'(WL_num),         256'(0));
    repeat (5) step();
    check("abort_no_done", 256'(done_count), 256'(0));

    // start and abort together in IDLE, then start re-pulsed while busy.
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check("sa_busy",  256'(busy),      256'(0));
    check("sa_ready", 256'(row_ready), 256'(0));
    done_count = 0;
    start = 1'b1;
    step();
    for (int i = 0; i < 400 && ph != PH_IDLE; i++) begin
      start = ($urandom_range(9) == 0);
      row_data = rand_row();
      step();
    end
    start = 1'b0;
    check("repulse_done_once", 256'(done_count), 256'(1));

    // Random row_valid with an asynchronous reset mid-run, then a full random run.
    done_count = 0;
    start = 1'b1; row_valid = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 400 && !(row == 10 && ph > 0); i++) begin
      row_valid = ($urandom_range(99) < 60);
      row_data = rand_row();
      step();
    end
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    rst_n = 1'b1;
    check("areset_no_done", 256'(done_count), 256'(0));
    start = 1'b1;
    step();
    start = 1'b0;
    run_to_idle(3000, 50);
    check("random_done_once", 256'(done_count), 256'(1));

`ifdef WLSEQ_SINGLE_ROW_EN
    done_count = 0; ae_pulses = 0;
    single_row = 1'b1; row_sel = RW'(33); start = 1'b1;
    step();
    start = 1'b0;
    run_to_idle(200, 70);
    check("single_ae_pulses", 256'(ae_pulses),  256'(1));
    check("single_done_once", 256'(done_count), 256'(1));
    row_sel = RW'(50); start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    check("single_oob_busy", 256'(busy), 256'(0));
    single_row = 1'b0;
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wl_program_sequencer.md
Name: wl_program_sequencer

Overview:
- Sequences programming of the coupling-weight array one word line at a time.
- Fetches one row of weight data per word line over a valid/ready handshake.
- Drives the word-line decoder inputs (address_enable, WL_num, prechargeb) and the bitline data bus through a precharge → write → gap cycle per row.
- Sits between the host/config loader and the array decoder and bitline drivers; it is the only block that drives the decoder.

Parameters:
- ARRAY_SIZE, default `ARRAY_SIZE (50): number of word lines and cells per row.
- WEIGHT_BITS, default 4: bits per cell on the bitline bus.
- PRECHARGE_CYCLES, default 2: cycles prechargeb is held low per row (≥1).
- WRITE_CYCLES, default 2: cycles address_enable is held high per row (≥1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin full-array program; sampled only in IDLE.
- abort  in  1  terminate the current program.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  one-cycle pulse on completion.
- row_valid  in  1  source has row data.
- row_ready  out  1  high only in FETCH.
- row_data  in  ARRAY_SIZE*WEIGHT_BITS  weights for the current row.
- address_enable  out  1  to decoder.
- WL_num  out  $clog2(ARRAY_SIZE)  to decoder.
- prechargeb  out  1  to decoder and bitline precharge; active low.
- bl_data  out  ARRAY_SIZE*WEIGHT_BITS  latched row data to bitline drivers.
- bl_drive_en  out  1  bitline driver enable.

Behaviour:
- Reset values: busy=0, done=0, row_ready=0, address_enable=0, prechargeb=1, WL_num=0, bl_data=0, bl_drive_en=0, state=IDLE.
- All outputs are registered.
- States: IDLE, FETCH, PRECH, WRITE, GAP, DONE.
- IDLE:
  - start=1 and abort=0 → FETCH, with WL_num=0.
  - start while not IDLE is ignored.
- FETCH:
  - row_ready=1.
  - On row_valid&&row_ready: latch row_data into bl_data, then → PRECH.
  - row_valid low stalls indefinitely; all decoder outputs hold idle values.
- PRECH:
  - prechargeb=0 for exactly PRECHARGE_CYCLES, then → WRITE.
  - Phase length is counted by a down counter loaded on entry.
- WRITE:
  - address_enable=1, prechargeb=1, bl_drive_en=1 for exactly WRITE_CYCLES, then → GAP.
- GAP:
  - One cycle with address_enable=0 and bl_drive_en=0.
  - If WL_num==ARRAY_SIZE-1 → DONE.
  - Otherwise WL_num increments on GAP exit and → FETCH.
- DONE: done=1 for one cycle, WL_num returns to 0, → IDLE.
- Invariants:
  - address_enable and prechargeb=0 are never simultaneously asserted.
  - WL_num changes only while address_enable=0.
  - WL_num never exceeds ARRAY_SIZE-1; there is no wrap-around.
  - bl_data is stable while bl_drive_en=1.
- Latency: with row_valid held high, done is high in cycle ARRAY_SIZE*(PRECHARGE_CYCLES+WRITE_CYCLES+2)+1 after the start-sampling edge.
- Abort:
  - abort=1 in any state other than IDLE → IDLE on the next edge.
  - All outputs return to their reset values and done is not pulsed.
  - abort and start both high in IDLE: abort wins and the block stays in IDLE.
  - abort during WRITE drops address_enable on that edge; the partially written row is left as is.
- Asynchronous reset mid-operation: immediate reset values, no done.

Optional Feature:
- Macro WLSEQ_SINGLE_ROW_EN.
- Defined:
  - Adds inputs single_row (1) and row_sel ($clog2(ARRAY_SIZE)).
  - start with single_row=1 loads WL_num=row_sel and runs one FETCH→PRECH→WRITE→GAP pass, then DONE.
  - row_sel≥ARRAY_SIZE: start is ignored and the block stays in IDLE.
- Undefined: the ports are absent and every start programs the full array.

Decomposition:
- Package wlseq_pkg holds:
  - state encoding constants;
  - ROW_W=$clog2(ARRAY_SIZE);
  - default timing constants.
- One sub-module, wlseq_phase_timer: a loadable down counter with a zero flag, shared by PRECH and WRITE.

Test Plan:
- Full program, ARRAY_SIZE=50, P=2, W=2, row_valid held high:
  - WL_num steps 0..49, one value per row;
  - 50 address_enable pulses, each 2 cycles wide;
  - done at cycle 301 after start; WL_num=0 afterwards.
- Backpressure: row_valid low for 5 cycles at row 7:
  - block stalls in FETCH with address_enable=0 and prechargeb=1;
  - resumes and completes with bl_data equal to the row-7 data during its WRITE.
- Abort asserted in the 2nd WRITE cycle of row 20: next cycle busy=0, address_enable=0, WL_num=0, no done pulse.
- start and abort high together in IDLE: no state change; start re-pulsed during busy is ignored and done appears exactly once.
- Invariant checker over a random row_valid pattern:
  - never address_enable=1 with prechargeb=0;
  - WL_num never changes while address_enable=1.
- WLSEQ_SINGLE_ROW_EN:
  - row_sel=33 → exactly one WRITE with WL_num=33, then done;
  - row_sel=50 → start ignored, busy stays 0.
